run_ctrl: RTL and testbench

Top-level run sequencer for the 9-bit core. It owns the Start/Done handshake with the test harness and holds the program counter in reset while a program is selected and loaded. It gates execution through `RunEn`, watches the decoder's `Ack` (halt) line to end a run, and keeps cycle and retired-instruction counters for performance reporting. It sits between the harness and the program counter, register file and data memory write enables.

---
 rtl/run_ctrl.sv | 138 +++++++++++++
 tb/tb_run_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - run sequencer: start/done handshake, PC reset hold, run gating, perf counters
// Optional feature macro: RUN_WATCHDOG_EN (ends a run with Timeout once CycleCount reaches MAX_CYCLES)
module run_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned INIT_CYCLES = 2,
  parameter logic [9:0]  PROG0_ADDR  = 10'd0,
  parameter logic [9:0]  PROG1_ADDR  = 10'd256,
  parameter logic [9:0]  PROG2_ADDR  = 10'd512,
  parameter logic [15:0] MAX_CYCLES  = 16'hFFF0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             Ack,
  input  logic             Stall,
  output logic             PCReset,
  output logic [9:0]       StartAddr,
  output logic             RunEn,
  output logic             Done,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCount,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [3:0] INIT_C = 4'(INIT_CYCLES);

  state_t           state;
  logic [3:0]       init_cnt;
  logic [9:0]       start_addr;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] ins_cnt;
  logic [CNT_W-1:0] cyc_inc;
  logic [CNT_W-1:0] ins_inc;
  logic             load_init;

  // ProgSel 3 has no program of its own and falls back to program 0
  function automatic logic [9:0] sel_addr(input logic [1:0] sel);
    case (sel)
      2'd1:    sel_addr = PROG1_ADDR;
      2'd2:    sel_addr = PROG2_ADDR;
      default: sel_addr = PROG0_ADDR;
    endcase
  endfunction

  // Saturating next values: the counters stick at all-ones instead of wrapping
  assign cyc_inc = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + CNT_W'(1);
  assign ins_inc = (ins_cnt == '1) ? ins_cnt : ins_cnt + CNT_W'(1);

  // Start from IDLE or DONE begins a run; in RUN it is an abort that outranks Ack
  assign load_init = Start && (state != S_INIT);

`ifdef RUN_WATCHDOG_EN
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);

  logic timeout_q;
  logic wd_hit;

  // Trip when this RUN cycle brings the cycle count up to the limit
  assign wd_hit  = (cyc_inc >= MAX_C);
  assign Timeout = timeout_q;
`else
  assign Timeout = 1'b0;
`endif

  // Sequencer state, latched start address and performance counters
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      init_cnt   <= '0;
      start_addr <= PROG0_ADDR;
      cyc_cnt    <= '0;
      ins_cnt    <= '0;
`ifdef RUN_WATCHDOG_EN
      timeout_q  <= 1'b0;
`endif
    end else if (load_init) begin
      state      <= S_INIT;
      init_cnt   <= '0;
      start_addr <= sel_addr(ProgSel);
      cyc_cnt    <= '0;
      ins_cnt    <= '0;
`ifdef RUN_WATCHDOG_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_INIT: begin
          if (init_cnt < INIT_C) begin
            init_cnt <= init_cnt + 4'd1;
          end
          // A held Start parks the block here until the harness lets go
          if (!Start && (init_cnt >= INIT_C)) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          cyc_cnt <= cyc_inc;
          if (!Stall) begin
            ins_cnt <= ins_inc;
          end
`ifdef RUN_WATCHDOG_EN
          if (wd_hit) begin
            state     <= S_DONE;
            timeout_q <= 1'b1;
          end else if (Ack && !Stall) begin
            state <= S_DONE;
          end
`else
          // A halt seen while stalled has not executed yet, so wait for it to retire
          if (Ack && !Stall) begin
            state <= S_DONE;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from registered state; RunEn is also gated by Stall in the same cycle
  // so a stalled instruction never advances the PC or writes back
  assign PCReset    = (state == S_IDLE) || (state == S_INIT);
  assign RunEn      = (state == S_RUN) && !Stall;
  assign Done       = (state == S_DONE);
  assign StartAddr  = start_addr;
  assign CycleCount = cyc_cnt;
  assign InstrCount = ins_cnt;

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - directed self-checking bench for run_ctrl
module tb_run_ctrl;

  localparam int CNT_W = 5;

  logic             Clk;
  logic             Reset;
  logic             Start;
  logic [1:0]       ProgSel;
  logic             Ack;
  logic             Stall;
  logic             PCReset;
  logic [9:0]       StartAddr;
  logic             RunEn;
  logic             Done;
  logic             Timeout;
  logic [CNT_W-1:0] CycleCount;
  logic [CNT_W-1:0] InstrCount;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  run_ctrl #(
    .CNT_W      (CNT_W),
    .INIT_CYCLES(2),
    .PROG0_ADDR (10'd0),
    .PROG1_ADDR (10'd256),
    .PROG2_ADDR (10'd512),
    .MAX_CYCLES (16'd20)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .ProgSel   (ProgSel),
    .Ack       (Ack),
    .Stall     (Stall),
    .PCReset   (PCReset),
    .StartAddr (StartAddr),
    .RunEn     (RunEn),
    .Done      (Done),
    .Timeout   (Timeout),
    .CycleCount(CycleCount),
    .InstrCount(InstrCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_run(output int cnt);
    cnt = 0;
    while (PCReset && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("run_entry_in_bound", 32'(cnt < 40), 1);
  endtask

  initial begin
    Reset   = 1'b1;
    Start   = 1'b0;
    ProgSel = 2'd0;
    Ack     = 1'b0;
    Stall   = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_pcreset", 32'(PCReset), 1);
    chk("rst_runen", 32'(RunEn), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_timeout", 32'(Timeout), 0);
    chk("rst_startaddr", 32'(StartAddr), 0);
    chk("rst_cycles", 32'(CycleCount), 0);
    chk("rst_instrs", 32'(InstrCount), 0);
    Reset = 1'b0;
    tick();

    // Run A: program 1, one-cycle Start, halt on the 10th unstalled RUN cycle
    Start   = 1'b1;
    ProgSel = 2'd1;
    tick();
    Start = 1'b0;
    chk("a_startaddr", 32'(StartAddr), 256);
    chk("a_init_pcreset", 32'(PCReset), 1);
    wait_run(n);
    chk("a_init_len", 32'(n >= 2 && n <= 3), 1);
    chk("a_run_cycles0", 32'(CycleCount), 0);
    chk("a_run_runen", 32'(RunEn), 1);
    for (int i = 1; i <= 10; i++) begin
      Ack = (i == 10);
      tick();
    end
    Ack = 1'b0;
    chk("a_done", 32'(Done), 1);
    chk("a_done_runen", 32'(RunEn), 0);
    chk("a_done_pcreset", 32'(PCReset), 0);
    chk("a_cycles", 32'(CycleCount), 10);
    chk("a_instrs", 32'(InstrCount), 10);
    tick();
    chk("a_frozen_cycles", 32'(CycleCount), 10);

    // Run B: restart from DONE with program 2, three stalls including the first Ack cycle
    Start   = 1'b1;
    ProgSel = 2'd2;
    tick();
    Start = 1'b0;
    chk("b_done_drop", 32'(Done), 0);
    chk("b_startaddr", 32'(StartAddr), 512);
    chk("b_cycles_clr", 32'(CycleCount), 0);
    wait_run(n);
    for (int i = 1; i <= 13; i++) begin
      Stall = (i == 4 || i == 9 || i == 12);
      Ack   = (i >= 12);
      tick();
      if (i == 12) chk("b_ack_stalled_hold", 32'(Done), 0);
    end
    Stall = 1'b0;
    Ack   = 1'b0;
    chk("b_done", 32'(Done), 1);
    chk("b_cycles", 32'(CycleCount), 13);
    chk("b_instrs", 32'(InstrCount), 10);

    // Run C: Start held 6 cycles, ProgSel 3 maps to program 0
    Start   = 1'b1;
    ProgSel = 2'd3;
    repeat (6) tick();
    chk("c_held_pcreset", 32'(PCReset), 1);
    chk("c_held_done", 32'(Done), 0);
    chk("c_startaddr", 32'(StartAddr), 0);
    Start = 1'b0;
    wait_run(n);
    chk("c_exit_after_release", 32'(n), 1);
    chk("c_entry_cycles", 32'(CycleCount), 0);
    chk("c_entry_instrs", 32'(InstrCount), 0);
    chk("c_entry_runen", 32'(RunEn), 1);

    // Abort at CycleCount 5 with Ack also high: abort wins
    repeat (5) tick();
    chk("d_cycles5", 32'(CycleCount), 5);
    Start = 1'b1;
    Ack   = 1'b1;
    tick();
    Start = 1'b0;
    Ack   = 1'b0;
    chk("d_abort_pcreset", 32'(PCReset), 1);
    chk("d_abort_done", 32'(Done), 0);
    chk("d_abort_cycles", 32'(CycleCount), 0);
    chk("d_abort_instrs", 32'(InstrCount), 0);
    wait_run(n);

`ifdef RUN_WATCHDOG_EN
    repeat (19) tick();
    chk("wd_before_limit", 32'(Done), 0);
    tick();
    chk("wd_done", 32'(Done), 1);
    chk("wd_timeout", 32'(Timeout), 1);
    chk("wd_cycles", 32'(CycleCount), 20);
    chk("wd_instrs", 32'(InstrCount), 20);
`else
    repeat (40) tick();
    chk("nowd_done", 32'(Done), 0);
    chk("nowd_timeout", 32'(Timeout), 0);
    chk("nowd_in_run", 32'(PCReset), 0);
    chk("sat_cycles", 32'(CycleCount), 31);
    chk("sat_instrs", 32'(InstrCount), 31);
`endif

    // Restart (from DONE or as abort), then asynchronous reset mid-run
    Start   = 1'b1;
    ProgSel = 2'd2;
    tick();
    Start = 1'b0;
    chk("e_timeout_clr", 32'(Timeout), 0);
    chk("e_startaddr", 32'(StartAddr), 512);
    wait_run(n);
    repeat (3) tick();
    chk("e_runen", 32'(RunEn), 1);
    chk("e_cycles", 32'(CycleCount), 3);
    #1;
    Reset = 1'b1;
    #1;
    chk("e_async_pcreset", 32'(PCReset), 1);
    chk("e_async_runen", 32'(RunEn), 0);
    chk("e_async_cycles", 32'(CycleCount), 0);
    chk("e_async_startaddr", 32'(StartAddr), 0);
    Reset = 1'b0;
    tick();
    chk("e_idle_pcreset", 32'(PCReset), 1);
    chk("e_idle_done", 32'(Done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
